// File: rtl/hough_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hough_frame_ctrl: frame sequencer; clears the pipe, admits one frame of     |
// | image/mask pixels, waits for hough, then streams thresholded peaks.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module hough_frame_ctrl #(
  parameter int PIXELS         = 921600,
  parameter int RHO_RANGE      = 1469,
  parameter int THETAS         = 180,
  parameter int THRESHOLD      = 64,
  parameter int CLR_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        frame_start,
  output logic                                        busy,
  output logic                                        frame_done,
  output logic                                        error,
  output logic [15:0]                                 peak_count,
  output logic                                        pipe_clear,
  input  logic                                        host_image_wr_en,
  input  logic [23:0]                                 host_image_din,
  output logic                                        host_image_full,
  input  logic                                        host_mask_wr_en,
  input  logic [23:0]                                 host_mask_din,
  output logic                                        host_mask_full,
  output logic                                        image_wr_en,
  output logic [23:0]                                 image_din,
  input  logic                                        image_full,
  output logic                                        mask_wr_en,
  output logic [23:0]                                 mask_din,
  input  logic                                        mask_full,
  input  logic                                        hough_done,
  input  logic [0:RHO_RANGE-1][0:THETAS-1][15:0]      accum_buff_out,
  output logic                                        out_wr_en,
  input  logic                                        out_full,
  output logic [$clog2(RHO_RANGE)+$clog2(THETAS)+15:0] out_din
);

  localparam int c_RW  = $clog2(RHO_RANGE);
  localparam int c_TW  = $clog2(THETAS);
  localparam int c_PW  = $clog2(PIXELS + 1);
  localparam int c_TMW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_CCW = $clog2(CLR_CYCLES + 1);

  localparam logic [c_PW-1:0]  c_PIX        = c_PW'(PIXELS);
  localparam logic [c_RW-1:0]  c_RHO_LAST   = c_RW'(RHO_RANGE - 1);
  localparam logic [c_TW-1:0]  c_THETA_LAST = c_TW'(THETAS - 1);
  localparam logic [c_TMW-1:0] c_TMO_LAST   = c_TMW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CCW-1:0] c_CLR_LAST   = c_CCW'(CLR_CYCLES - 1);
  localparam logic [15:0]      c_THR        = 16'(THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_SCAN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_error;
  logic [15:0]         r_peak_count;
  logic                r_pipe_clear;
  logic [c_CCW-1:0]    r_clr_cnt;
  logic [c_PW-1:0]     r_img_cnt;
  logic [c_PW-1:0]     r_mask_cnt;
  logic [c_TMW-1:0]    r_timer;
  logic [c_RW-1:0]     r_rho;
  logic [c_TW-1:0]     r_theta;
  logic                r_out_wr_en;
  logic [c_RW+c_TW+15:0] r_out_din;

  logic        w_in_load;
  logic        w_img_room;
  logic        w_mask_room;
  logic [15:0] w_votes;
  logic        w_is_peak;
  logic        w_advance;
  logic        w_last;

  // Host writes reach the pipeline only while loading and only up to one frame.
  assign w_in_load   = (r_state == S_LOAD);
  assign w_img_room  = (r_img_cnt != c_PIX);
  assign w_mask_room = (r_mask_cnt != c_PIX);

  assign image_wr_en     = w_in_load & host_image_wr_en & ~image_full & w_img_room;
  assign mask_wr_en      = w_in_load & host_mask_wr_en & ~mask_full & w_mask_room;
  assign image_din       = w_in_load ? host_image_din : 24'd0;
  assign mask_din        = w_in_load ? host_mask_din : 24'd0;
  assign host_image_full = image_full | ~w_img_room | ~w_in_load;
  assign host_mask_full  = mask_full | ~w_mask_room | ~w_in_load;

  assign w_votes   = accum_buff_out[r_rho][r_theta];
  assign w_is_peak = (w_votes >= c_THR);
  // A peak holds the scan index until the downstream FIFO can take it.
  assign w_advance = ~w_is_peak | ~out_full;
  assign w_last    = (r_rho == c_RHO_LAST) && (r_theta == c_THETA_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
      r_peak_count <= 16'd0;
      r_pipe_clear <= 1'b0;
      r_clr_cnt    <= '0;
      r_img_cnt    <= '0;
      r_mask_cnt   <= '0;
      r_timer      <= '0;
      r_rho        <= '0;
      r_theta      <= '0;
      r_out_wr_en  <= 1'b0;
      r_out_din    <= '0;
    end else begin
      r_out_wr_en  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state      <= S_CLEAR;
            r_busy       <= 1'b1;
            r_pipe_clear <= 1'b1;
            r_error      <= 1'b0;
            r_peak_count <= 16'd0;
            r_clr_cnt    <= '0;
            r_img_cnt    <= '0;
            r_mask_cnt   <= '0;
            r_timer      <= '0;
            r_rho        <= '0;
            r_theta      <= '0;
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == c_CLR_LAST) begin
            r_pipe_clear <= 1'b0;
            r_state      <= S_LOAD;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (image_wr_en) r_img_cnt <= r_img_cnt + 1'b1;
          if (mask_wr_en)  r_mask_cnt <= r_mask_cnt + 1'b1;
          if (!w_img_room && !w_mask_room) begin
            r_state <= S_WAIT;
            r_timer <= '0;
          end
        end
        S_WAIT: begin
          if (hough_done) begin
            r_state <= S_SCAN;
            r_rho   <= '0;
            r_theta <= '0;
          end else if (r_timer == c_TMO_LAST) begin
            r_error      <= 1'b1;
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_SCAN: begin
          if (w_is_peak && !out_full) begin
            r_out_wr_en <= 1'b1;
            r_out_din   <= {r_rho, r_theta, w_votes};
            if (r_peak_count != 16'hFFFF) r_peak_count <= r_peak_count + 1'b1;
          end
          if (w_advance) begin
            if (w_last) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end else if (r_theta == c_THETA_LAST) begin
              r_theta <= '0;
              r_rho   <= r_rho + 1'b1;
            end else begin
              r_theta <= r_theta + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign error      = r_error;
  assign peak_count = r_peak_count;
  assign pipe_clear = r_pipe_clear;
  assign out_wr_en  = r_out_wr_en;
  assign out_din    = r_out_din;

endmodule
`default_nettype wire
